// File: rtl/rv32i_multiplier_unit_pkg.sv
// rv32i_multiplier_unit_pkg: shared state encoding and widths for the shift-add multiplier
package rv32i_multiplier_unit_pkg;
  typedef enum logic [1:0] {MulIdle, MulCompute, MulDone, MulWaitRelease} mul_state_t;
  localparam int MUL_OPERAND_WIDTH = 16;
  localparam int MUL_RESULT_WIDTH = 32;
endpackage

// File: rtl/rv32i_multiplier_unit_pp_gen.sv
// rv32i_multiplier_unit_pp_gen: sum of shifted multiplicand copies selected by a slice of multiplier bits
module rv32i_multiplier_unit_pp_gen #(
  parameter int WIDTH = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
  output logic [WIDTH-1:0]          pp
);
  // one shifted copy of the multiplicand per set multiplier bit
  always_comb begin
    pp = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) pp = pp + (mplier_bits[j] ? mcand << j : '0);
  end
endmodule

// File: rtl/rv32i_multiplier_unit.sv
// rv32i_multiplier_unit: multicycle unsigned radix-2^BITS_PER_CYCLE shift-add multiplier
module rv32i_multiplier_unit
  import rv32i_multiplier_unit_pkg::*;
#(
  parameter int OPERAND_WIDTH = MUL_OPERAND_WIDTH,
  parameter int BITS_PER_CYCLE = 2,
  parameter bit EARLY_TERMINATE = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_multiplier_en,
  input  logic [OPERAND_WIDTH-1:0]   i_multiplier_operand_one,
  input  logic [OPERAND_WIDTH-1:0]   i_multiplier_operand_two,
  output logic                       o_multiplier_valid,
  output logic [2*OPERAND_WIDTH-1:0] o_multiplier_result,
  output logic                       o_multiplier_busy
);
  localparam int RW = 2 * OPERAND_WIDTH;
  localparam int ITER = OPERAND_WIDTH / BITS_PER_CYCLE;
  localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
  if (OPERAND_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide OPERAND_WIDTH");
  end
  mul_state_t state, state_n;
  logic [RW-1:0] mcand, acc, acc_n, pp;
  logic [OPERAND_WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  logic last, finish;
  rv32i_multiplier_unit_pp_gen #(.WIDTH(RW), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_pp_gen (
    .mcand(mcand),
    .mplier_bits(mplier[BITS_PER_CYCLE-1:0]),
    .pp(pp)
  );
  assign acc_n = acc + pp;
  assign last = cnt == CW'(ITER - 1) || (EARLY_TERMINATE && (mplier >> BITS_PER_CYCLE) == '0);
  assign finish = state == MulCompute && i_multiplier_en && last;
  assign o_multiplier_busy = state != MulIdle;
  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= MulIdle;
    else state <= state_n;
  end
  // next state: dropping en during COMPUTE aborts, en held after DONE waits for release
  always_comb begin
    state_n = state;
    unique case (state)
      MulIdle:    state_n = i_multiplier_en ? MulCompute : MulIdle;
      MulCompute: state_n = !i_multiplier_en ? MulIdle : last ? MulDone : MulCompute;
      MulDone:    state_n = MulWaitRelease;
      default:    state_n = i_multiplier_en ? MulWaitRelease : MulIdle;
    endcase
  end
  // operand latch, shift-add datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      o_multiplier_valid <= 1'b0;
      o_multiplier_result <= '0;
    end else begin
      if (state == MulIdle && i_multiplier_en) begin
        mcand <= RW'(i_multiplier_operand_one);
        mplier <= i_multiplier_operand_two;
        acc <= '0;
        cnt <= '0;
      end
      if (state == MulCompute) begin
        acc <= acc_n;
        mcand <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt <= cnt + CW'(1);
      end
      o_multiplier_valid <= finish;
      if (finish) o_multiplier_result <= acc_n;
    end
  end
endmodule

// File: tb/tb_rv32i_multiplier_unit.sv
// tb_rv32i_multiplier_unit: scoreboard bench, unit 0 without and unit 1 with early termination
module tb_rv32i_multiplier_unit;
  localparam int ITER = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en [2];
  logic [15:0] op1 [2];
  logic [15:0] op2 [2];
  logic valid [2];
  logic [31:0] result [2];
  logic busy [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] last_exp [2];
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32i_multiplier_unit #(.EARLY_TERMINATE(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_multiplier_en(en[0]),
    .i_multiplier_operand_one(op1[0]), .i_multiplier_operand_two(op2[0]),
    .o_multiplier_valid(valid[0]), .o_multiplier_result(result[0]), .o_multiplier_busy(busy[0])
  );
  rv32i_multiplier_unit #(.EARLY_TERMINATE(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_multiplier_en(en[1]),
    .i_multiplier_operand_one(op1[1]), .i_multiplier_operand_two(op2[1]),
    .o_multiplier_valid(valid[1]), .o_multiplier_result(result[1]), .o_multiplier_busy(busy[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // cycles from issuing en to seeing valid: one per compute step plus the accept cycle
  function automatic int exp_lat(input int u, input logic [15:0] b);
    int bl = 0;
    for (int i = 0; i < 16; i++) if (b[i]) bl = i + 1;
    if (u == 0) return ITER + 1;
    return b == 0 ? 2 : (bl + 1) / 2 + 1;
  endfunction

  task automatic do_mul(input int u, input logic [15:0] a, input logic [15:0] b, input int hold);
    int n = 0;
    @(negedge clk);
    op1[u] = a;
    op2[u] = b;
    en[u] = 1'b1;
    if (u == 0) q0.push_back(32'(a) * 32'(b));
    else q1.push_back(32'(a) * 32'(b));
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check($sformatf("busy_compute%0d", u), 32'(busy[u]), 32'd1);
        op1[u] = 16'($urandom);
        op2[u] = 16'($urandom);
      end
      if (valid[u]) break;
    end
    check($sformatf("latency%0d 0x%04h*0x%04h", u, a, b), n, exp_lat(u, b));
    repeat (hold) @(negedge clk);
    en[u] = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("busy_release%0d", u), 32'(busy[u]), 32'd0);
  endtask

  task automatic abort_mul(input int u, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op1[u] = a;
    op2[u] = b;
    en[u] = 1'b1;
    repeat (4) @(negedge clk);
    en[u] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy[u]), 32'd0);
    check("abort_result", result[u], last_exp[u]);
  endtask

  // scoreboard monitors: each valid pops one expected product
  always @(negedge clk) begin
    if (valid[0]) begin
      check("double_valid0", 32'(prev_v0), 32'd0);
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid0: got result 0x%08h expected no valid", result[0]);
      end else begin
        last_exp[0] = q0.pop_front();
        check("result0", result[0], last_exp[0]);
      end
    end
    prev_v0 = valid[0];
  end

  always @(negedge clk) begin
    if (valid[1]) begin
      check("double_valid1", 32'(prev_v1), 32'd0);
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid1: got result 0x%08h expected no valid", result[1]);
      end else begin
        last_exp[1] = q1.pop_front();
        check("result1", result[1], last_exp[1]);
      end
    end
    prev_v1 = valid[1];
  end

  function automatic logic [15:0] rnd_op();
    int s = $urandom_range(0, 7);
    return s == 0 ? 16'h0000 : s == 1 ? 16'hFFFF : s == 2 ? 16'($urandom_range(0, 15)) : 16'($urandom);
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      en[u] = 1'b0;
      op1[u] = '0;
      op2[u] = '0;
      last_exp[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_valid%0d", u), 32'(valid[u]), 32'd0);
      check($sformatf("reset_result%0d", u), result[u], 32'd0);
      check($sformatf("reset_busy%0d", u), 32'(busy[u]), 32'd0);
    end
    rst = 1'b0;
    do_mul(0, 16'h0003, 16'h0005, 0);
    do_mul(0, 16'hFFFF, 16'hFFFF, 0);
    do_mul(0, 16'h0000, 16'h1234, 0);
    do_mul(0, 16'h1234, 16'h0010, 0);
    do_mul(0, 16'h00FF, 16'h0101, 0);
    abort_mul(0, 16'hABCD, 16'h1357);
    do_mul(0, 16'h0007, 16'h0009, 0);
    @(negedge clk);
    op1[0] = 16'h4321;
    op2[0] = 16'h8765;
    en[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b0;
    check("rst_mid_valid", 32'(valid[0]), 32'd0);
    check("rst_mid_result", result[0], 32'd0);
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    last_exp[0] = '0;
    last_exp[1] = '0;
    do_mul(0, 16'h0101, 16'h0202, 0);
    do_mul(0, 16'hBEEF, 16'h00F0, 5);
    do_mul(1, 16'h0003, 16'h0005, 0);
    do_mul(1, 16'h0000, 16'h1234, 0);
    do_mul(1, 16'hFFFF, 16'hFFFF, 3);
    abort_mul(1, 16'h1111, 16'hF000);
    fork
      for (int k = 0; k < 40; k++) do_mul(0, rnd_op(), rnd_op(), $urandom_range(0, 2));
      for (int k = 0; k < 40; k++) do_mul(1, rnd_op(), rnd_op(), $urandom_range(0, 2));
    join
    repeat (3) @(negedge clk);
    check("drain0", q0.size(), 32'd0);
    check("drain1", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
